// File: rtl/esi_axi_stream_packer_if.sv
// Bundle for the packer: narrow rv input side plus the AXI-Stream output side.
// master = packer view, slave = producer/sink environment view.
interface esi_axi_stream_packer_if #(
  parameter int TDATA_WIDTH   = 64,
  parameter int DATA_IN_WIDTH = 32
);
  logic                       TVALID;
  logic                       TREADY;
  logic [TDATA_WIDTH-1:0]     TDATA;
  logic [TDATA_WIDTH/8-1:0]   TKEEP;
  logic                       TLAST;
  logic [DATA_IN_WIDTH-1:0]   data_in;
  logic                       data_in_valid;
  logic                       data_in_ready;
  logic                       data_in_last;

  modport master (
    output TVALID, TDATA, TKEEP, TLAST, data_in_ready,
    input  TREADY, data_in, data_in_valid, data_in_last
  );

  modport slave (
    input  TVALID, TDATA, TKEEP, TLAST, data_in_ready,
    output TREADY, data_in, data_in_valid, data_in_last
  );
endinterface

// File: rtl/esi_axi_stream_packer.sv
// Packs RATIO narrow rv words into one AXI-Stream beat; data_in_last closes a
// partially filled beat early. Output beat is fully registered.
module esi_axi_stream_packer #(
  parameter int TDATA_WIDTH   = 64,
  parameter int DATA_IN_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  esi_axi_stream_packer_if.master bus
);
  localparam int RATIO = TDATA_WIDTH / DATA_IN_WIDTH;
  localparam int KW    = TDATA_WIDTH / 8;
  localparam int LKW   = DATA_IN_WIDTH / 8;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if ((TDATA_WIDTH % DATA_IN_WIDTH) != 0 || (DATA_IN_WIDTH % 8) != 0 || RATIO < 1) begin : g_param_check
    $error("esi_axi_stream_packer: illegal TDATA_WIDTH/DATA_IN_WIDTH combination");
  end

  logic [TDATA_WIDTH-1:0] acc_q, acc_d;
  logic [KW-1:0]          keep_q, keep_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   tvalid_q, tvalid_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KW-1:0]          tkeep_q, tkeep_d;
  logic                   tlast_q, tlast_d;

  logic [TDATA_WIDTH-1:0] merged_data;
  logic [KW-1:0]          merged_keep;
  logic                   accept;
  logic                   complete;

  // Ready only looks at the output register and the sink, never at data_in_valid.
  assign bus.data_in_ready = rst && (!tvalid_q || bus.TREADY);
  assign accept            = bus.data_in_valid && bus.data_in_ready;
  assign complete          = (idx_q == IDX_W'(RATIO - 1)) || bus.data_in_last;

  always_comb begin
    merged_data = acc_q;
    merged_keep = keep_q;
    for (int l = 0; l < RATIO; l++) begin
      if (idx_q == IDX_W'(l)) begin
        merged_data[l*DATA_IN_WIDTH +: DATA_IN_WIDTH] = bus.data_in;
        merged_keep[l*LKW +: LKW]                     = '1;
      end
    end
  end

  always_comb begin
    acc_d    = acc_q;
    keep_d   = keep_q;
    idx_d    = idx_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    if (tvalid_q && bus.TREADY) begin
      tvalid_d = 1'b0;
    end
    if (accept) begin
      if (complete) begin
        // A load on the same edge as a consume keeps TVALID high: no bubble.
        tvalid_d = 1'b1;
        tdata_d  = merged_data;
        tkeep_d  = merged_keep;
        tlast_d  = bus.data_in_last;
        acc_d    = '0;
        keep_d   = '0;
        idx_d    = '0;
      end else begin
        acc_d    = merged_data;
        keep_d   = merged_keep;
        idx_d    = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      keep_q   <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      keep_q   <= keep_d;
      idx_q    <= idx_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
    end
  end

  assign bus.TVALID = tvalid_q;
  assign bus.TDATA  = tdata_q;
  assign bus.TKEEP  = tkeep_q;
  assign bus.TLAST  = tlast_q;
endmodule

// File: tb/tb_esi_axi_stream_packer.sv
// Scoreboard bench for esi_axi_stream_packer (64/32) plus 32/32 and 128/32 instances.
module tb_esi_axi_stream_packer;
  localparam int TDW   = 64;
  localparam int DIW   = 32;
  localparam int RATIO = TDW / DIW;
  localparam int KW    = TDW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  esi_axi_stream_packer_if #(.TDATA_WIDTH(TDW), .DATA_IN_WIDTH(DIW)) bus ();
  esi_axi_stream_packer_if #(.TDATA_WIDTH(32),  .DATA_IN_WIDTH(32))  bus32 ();
  esi_axi_stream_packer_if #(.TDATA_WIDTH(128), .DATA_IN_WIDTH(32))  bus128 ();

  esi_axi_stream_packer #(.TDATA_WIDTH(TDW), .DATA_IN_WIDTH(DIW)) dut (.clk(clk), .rst(rst), .bus(bus));
  esi_axi_stream_packer #(.TDATA_WIDTH(32),  .DATA_IN_WIDTH(32))  dut32 (.clk(clk), .rst(rst), .bus(bus32));
  esi_axi_stream_packer #(.TDATA_WIDTH(128), .DATA_IN_WIDTH(32))  dut128 (.clk(clk), .rst(rst), .bus(bus128));

  typedef struct packed {
    logic [TDW-1:0] data;
    logic [KW-1:0]  keep;
    logic           last;
  } beat_t;

  beat_t          sb[$];
  beat_t          last_beat;
  logic [TDW-1:0] m_acc;
  logic [KW-1:0]  m_keep;
  int             m_idx = 0;
  int             checks = 0;
  int             errors = 0;
  int             beats_seen = 0;
  int             beats_pushed = 0;
  int             cyc = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and reference model, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t exp_b;
    if (!rst) begin
      sb.delete();
      m_acc  = '0;
      m_keep = '0;
      m_idx  = 0;
      check_eq("reset_ready", bus.data_in_ready, 1'b0);
      check_eq("reset_tvalid", bus.TVALID, 1'b0);
      check_eq("reset_tdata", bus.TDATA, '0);
      check_eq("reset_tkeep", bus.TKEEP, '0);
      check_eq("reset_tlast", bus.TLAST, 1'b0);
    end else begin
      check_eq("tvalid_vs_model", bus.TVALID, sb.size() != 0);
      check_eq("ready_rule", bus.data_in_ready, !bus.TVALID || bus.TREADY);
      if (bus.TVALID && bus.TREADY && sb.size() != 0) begin
        exp_b = sb.pop_front();
        check_eq("beat_tdata", bus.TDATA, exp_b.data);
        check_eq("beat_tkeep", bus.TKEEP, exp_b.keep);
        check_eq("beat_tlast", bus.TLAST, exp_b.last);
        last_beat  = '{data: bus.TDATA, keep: bus.TKEEP, last: bus.TLAST};
        beats_seen = beats_seen + 1;
      end
      if (bus.data_in_valid && bus.data_in_ready) begin
        m_acc[m_idx*DIW +: DIW]   = bus.data_in;
        m_keep[m_idx*(DIW/8) +: (DIW/8)] = '1;
        if (m_idx == RATIO - 1 || bus.data_in_last) begin
          sb.push_back('{data: m_acc, keep: m_keep, last: bus.data_in_last});
          beats_pushed = beats_pushed + 1;
          m_acc  = '0;
          m_keep = '0;
          m_idx  = 0;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end
  end

  // Called right after a rising edge; returns right after the accepting edge.
  task automatic send(input logic [DIW-1:0] d, input logic l);
    bit got_it = 1'b0;
    bus.data_in       = d;
    bus.data_in_last  = l;
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.data_in_ready) begin
        got_it = 1'b1;
        break;
      end
    end
    check_eq("send_accept_timeout", got_it, 1'b1);
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    bus.data_in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.TVALID) begin
        idle = 1'b1;
        break;
      end
    end
    check_eq("drain_timeout", idle, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int c0;
    bus.TREADY = 1'b0;  bus.data_in = '0;    bus.data_in_valid = 1'b0;    bus.data_in_last = 1'b0;
    bus32.TREADY = 1'b1; bus32.data_in = '0; bus32.data_in_valid = 1'b0;  bus32.data_in_last = 1'b0;
    bus128.TREADY = 1'b1; bus128.data_in = '0; bus128.data_in_valid = 1'b0; bus128.data_in_last = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    bus.TREADY = 1'b1;

    // 1: reset mid-beat discards the partial word
    send(32'h99999999, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    b0 = beats_seen;
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    wait_idle();
    check_eq("t1_beat_count", beats_seen - b0, 1);
    check_eq("t1_tdata", last_beat.data, 64'h2222222211111111);
    check_eq("t1_tkeep", last_beat.keep, 8'hFF);
    check_eq("t1_tlast", last_beat.last, 1'b0);

    // 2: partial beat closed by data_in_last, visible right after the accept edge
    send(32'hAAAAAAAA, 1'b1);
    check_eq("t2_tvalid", bus.TVALID, 1'b1);
    check_eq("t2_tdata", bus.TDATA, 64'h00000000AAAAAAAA);
    check_eq("t2_tkeep", bus.TKEEP, 8'h0F);
    check_eq("t2_tlast", bus.TLAST, 1'b1);
    send(32'h12345678, 1'b0);
    send(32'h9ABCDEF0, 1'b1);
    wait_idle();
    check_eq("t2_next_lane0", last_beat.data, 64'h9ABCDEF012345678);

    // 3: backpressure holds the beat and blocks input
    bus.TREADY = 1'b0;
    send(32'h00000001, 1'b0);
    send(32'h00000002, 1'b0);
    bus.data_in       = 32'h00000003;
    bus.data_in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("t3_ready_low", bus.data_in_ready, 1'b0);
      check_eq("t3_tdata_hold", bus.TDATA, 64'h0000000200000001);
      check_eq("t3_tkeep_hold", bus.TKEEP, 8'hFF);
      check_eq("t3_tlast_hold", bus.TLAST, 1'b0);
    end
    @(posedge clk);
    #1 bus.TREADY = 1'b1;
    @(negedge clk);
    check_eq("t3_ready_on_tready", bus.data_in_ready, 1'b1);
    @(posedge clk);
    #1 bus.data_in_valid = 1'b0;
    send(32'h00000004, 1'b1);
    wait_idle();
    check_eq("t3_after_release", last_beat.data, 64'h0000000400000003);

    // 4: full rate, 100 words -> 50 beats in 100 cycles
    b0 = beats_seen;
    c0 = cyc;
    for (int i = 0; i < 100; i++) send(DIW'(i), 1'b0);
    check_eq("t4_cycles", cyc - c0, 100);
    wait_idle();
    check_eq("t4_beat_count", beats_seen - b0, 50);
    check_eq("t4_last_beat", last_beat.data, {32'd99, 32'd98});

    // 5: random valid/ready/last
    repeat (10000) begin
      @(posedge clk);
      #1;
      bus.data_in_valid = ($urandom_range(0, 3) != 0);
      bus.data_in       = $urandom;
      bus.data_in_last  = ($urandom_range(0, 7) == 0);
      bus.TREADY        = ($urandom_range(0, 3) != 0);
    end
    bus.data_in_valid = 1'b0;
    bus.TREADY        = 1'b1;
    @(posedge clk);
    #1;
    send(32'h5A5A5A5A, 1'b1);
    wait_idle();
    check_eq("t5_no_loss", beats_seen, beats_pushed);
    check_eq("t5_sb_empty", sb.size(), 0);

    // 6a: RATIO=1 pass-through register
    bus32.data_in = 32'hDEADBEEF; bus32.data_in_last = 1'b0; bus32.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("r1_tvalid", bus32.TVALID, 1'b1);
    check_eq("r1_tdata", bus32.TDATA, 32'hDEADBEEF);
    check_eq("r1_tkeep", bus32.TKEEP, 4'hF);
    check_eq("r1_tlast0", bus32.TLAST, 1'b0);
    bus32.data_in = 32'hCAFEF00D; bus32.data_in_last = 1'b1;
    @(posedge clk);
    #1;
    check_eq("r1_tdata2", bus32.TDATA, 32'hCAFEF00D);
    check_eq("r1_tlast1", bus32.TLAST, 1'b1);
    bus32.data_in_valid = 1'b0; bus32.data_in_last = 1'b0;
    @(posedge clk);
    #1;
    check_eq("r1_tvalid_drop", bus32.TVALID, 1'b0);

    // 6b: RATIO=4, last on the third word
    bus128.data_in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus128.data_in      = 32'(i);
      bus128.data_in_last = (i == 3);
      @(posedge clk);
      #1;
      if (i < 3) check_eq("r4_no_early_beat", bus128.TVALID, 1'b0);
    end
    bus128.data_in_valid = 1'b0; bus128.data_in_last = 1'b0;
    check_eq("r4_tvalid", bus128.TVALID, 1'b1);
    check_eq("r4_tdata", bus128.TDATA, 128'h00000000_00000003_00000002_00000001);
    check_eq("r4_tkeep", bus128.TKEEP, 16'h0FFF);
    check_eq("r4_tlast", bus128.TLAST, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
